universal_shift_engine: RTL
===========================

UNIVERSAL_SHIFT_ENGINE -- requirements
Module: universal_shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (WIDTH >= 2).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), burst-count width.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port load  input  1  parallel load request.
REQ-006 SHALL have port d  input  WIDTH  parallel load data.
REQ-007 SHALL have port mode  input  2  shift mode: 00 logical right, 01 logical left, 10 rotate right, 11 arithmetic right.
REQ-008 SHALL have port ser_in  input  1  fill bit for logical modes.
REQ-009 SHALL have port shift_en  input  1  single-step shift request.
REQ-010 SHALL have port start  input  1  burst start request.
REQ-011 SHALL have port count  input  CNT_W  number of shifts in a burst.
REQ-012 SHALL have port q  output  WIDTH  register contents.
REQ-013 SHALL have port ser_out  output  1  bit ejected by the most recent shift.
REQ-014 SHALL have port busy  output  1  high while a burst is running.
REQ-015 SHALL have port done  output  1  one-cycle burst-complete pulse.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and RUN, with all outputs registered.
REQ-017 IDLE priority SHALL be load > start > shift_en; lower-priority requests in the same cycle are ignored.
REQ-018 IDLE load SHALL set q<=d with ser_out unchanged.
REQ-019 IDLE shift_en SHALL perform one shift using the current mode and ser_in.
REQ-020 A shift SHALL compute: mode 00 q<={ser_in,q[W-1:1]}, ser_out<=q[0]; mode 01 q<={q[W-2:0],ser_in}, ser_out<=q[W-1]; mode 10 q<={q[0],q[W-1:1]}, ser_out<=q[0]; mode 11 q<={q[W-1],q[W-1:1]}, ser_out<=q[0].
REQ-021 IDLE start with count=N>=1 at edge k SHALL latch mode and N, then enter RUN with busy=1 after edge k and q unchanged at edge k.
REQ-022 In RUN, one shift SHALL occur per edge at k+1..k+N, using the latched mode and the live ser_in.
REQ-023 At edge k+N the FSM SHALL return to IDLE with busy=0 and done=1; done SHALL clear at edge k+N+1.
REQ-024 IDLE start with count=0 SHALL set done=1 for one cycle, keep q unchanged, and leave busy at 0.
REQ-025 Count values greater than WIDTH SHALL be honoured exactly (no clamping).
REQ-026 In RUN, start, shift_en, and changes to mode or count SHALL be ignored.
REQ-027 In RUN, load SHALL abort the burst: q<=d, return to IDLE, busy=0, and no done pulse.
REQ-028 done and busy SHALL never be high in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force q=0, ser_out=0, busy=0, done=0, the FSM to IDLE, and the remaining count to 0.
REQ-030 Reset asserted mid-burst SHALL discard the burst with no done pulse; operation SHALL resume on the first clk edge after rst deasserts.

Structure
REQ-031 Package shift_pkg SHALL hold the mode encodings (MODE_LSR, MODE_LSL, MODE_ROR, MODE_ASR) and the FSM state type.
REQ-032 The combinational next-value/ejected-bit function SHALL be the sub-module shift_step (parameter WIDTH; inputs q, mode, ser_in; outputs q_nxt, bit_out), shared by the single-step and burst paths.

Verification (WIDTH=8)
REQ-033 The bench SHALL cover: load 8'hB4, then shift_en with mode 00 and ser_in=1 -> q=8'hDA, ser_out=0.
REQ-034 The bench SHALL cover: load 8'h81, then shift_en with mode 01 and ser_in=0 -> q=8'h02, ser_out=1.
REQ-035 The bench SHALL cover: load 8'h81, then start with count=3 and mode 10 -> busy for 3 cycles, then q=8'h30, done for one cycle.
REQ-036 The bench SHALL cover: load 8'h90, then start with count=2 and mode 11 -> q=8'hE4, done once; toggling mode during RUN has no effect.
REQ-037 The bench SHALL cover: start with count=0 -> done for one cycle, busy never high, q unchanged.
REQ-038 The bench SHALL cover: burst with count=5 aborted by load 8'h5A at the 2nd shift -> q=8'h5A, busy=0, no done; and async rst mid-burst -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift engine.
//   mode_t  : shift mode encodings driven on the 'mode' port
//   state_t : control FSM states (IDLE waits for requests, RUN executes a burst)
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,  // logical right, ser_in enters at the MSB
    MODE_LSL = 2'b01,  // logical left, ser_in enters at the LSB
    MODE_ROR = 2'b10,  // rotate right
    MODE_ASR = 2'b11   // arithmetic right, sign bit replicated
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step, used by both the single-step and burst paths.
// Ports:
//   q       in  WIDTH  current register value
//   mode    in  2      shift mode (shift_pkg::mode_t)
//   ser_in  in  1      fill bit for the logical modes
//   q_nxt   out WIDTH  register value after one shift
//   bit_out out 1      bit ejected by this shift
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_nxt,
  output logic             bit_out
);

  always_comb begin
    q_nxt   = q;
    bit_out = q[0];
    unique case (mode)
      MODE_LSR: begin
        q_nxt   = {ser_in, q[WIDTH-1:1]};
        bit_out = q[0];
      end
      MODE_LSL: begin
        q_nxt   = {q[WIDTH-2:0], ser_in};
        bit_out = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt   = {q[0], q[WIDTH-1:1]};
        bit_out = q[0];
      end
      MODE_ASR: begin
        q_nxt   = {q[WIDTH-1], q[WIDTH-1:1]};
        bit_out = q[0];
      end
      default: begin
        q_nxt   = q;
        bit_out = q[0];
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_engine.sv
// Universal shift register with parallel load, single-step shifts and
// counted bursts.
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      asynchronous active-high reset
//   load     in  1      parallel load request (also aborts a running burst)
//   d        in  WIDTH  parallel load data
//   mode     in  2      shift mode (see shift_pkg::mode_t)
//   ser_in   in  1      fill bit for logical modes (sampled live during bursts)
//   shift_en in  1      single-step shift request (IDLE only)
//   start    in  1      burst start request (IDLE only)
//   count    in  CNT_W  number of shifts in a burst
//   q        out WIDTH  register contents
//   ser_out  out 1      bit ejected by the most recent shift
//   busy     out 1      high while a burst is running (equals state == RUN)
//   done     out 1      one-cycle burst-complete pulse
//
// Request/response handshake: requests are single-cycle levels sampled on a
// rising edge and only honoured in IDLE, with priority load > start > shift_en.
// A start is acknowledged by busy rising after the same edge; completion is
// signalled by a one-cycle done pulse coincident with busy falling. A burst
// killed by load or rst produces no done. busy and done are never both high.
module universal_shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic             shift_en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  mode_t            mode_lat, mode_lat_nxt;
  logic [CNT_W-1:0] remain, remain_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             ser_out_nxt;
  logic             done_nxt;

  // Single shared shift datapath: the burst uses the latched mode, a single
  // step uses the live mode.
  mode_t            step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign step_mode = (state == ST_RUN) ? mode_lat : mode_t'(mode);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (q),
    .mode    (step_mode),
    .ser_in  (ser_in),
    .q_nxt   (step_q),
    .bit_out (step_bit)
  );

  always_comb begin
    state_nxt    = state;
    mode_lat_nxt = mode_lat;
    remain_nxt   = remain;
    q_nxt        = q;
    ser_out_nxt  = ser_out;
    done_nxt     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (load) begin
          q_nxt = d;
        end else if (start) begin
          if (count == '0) begin
            // Empty burst completes immediately without ever going busy.
            done_nxt = 1'b1;
          end else begin
            mode_lat_nxt = mode_t'(mode);
            remain_nxt   = count;
            state_nxt    = ST_RUN;
          end
        end else if (shift_en) begin
          q_nxt       = step_q;
          ser_out_nxt = step_bit;
        end
      end
      ST_RUN: begin
        if (load) begin
          q_nxt      = d;
          remain_nxt = '0;
          state_nxt  = ST_IDLE;
        end else begin
          q_nxt       = step_q;
          ser_out_nxt = step_bit;
          remain_nxt  = remain - CNT_W'(1);
          if (remain == CNT_W'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_lat <= MODE_LSR;
      remain   <= '0;
      q        <= '0;
      ser_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode_lat <= mode_lat_nxt;
      remain   <= remain_nxt;
      q        <= q_nxt;
      ser_out  <= ser_out_nxt;
      busy     <= (state_nxt == ST_RUN);
      done     <= done_nxt;
    end
  end

endmodule
